// File: rtl/pc_gen_btb_pkg.sv
// Shared types and constants for the fetch PC generator and its branch target buffer.
// Addresses are stored at the widest supported width; narrower instances zero-extend.
package pc_gen_btb_pkg;

  localparam int unsigned XLEN_MAX = 64;

  typedef logic [XLEN_MAX-1:0] addr_t;
  typedef logic [1:0]          ctr_t;

  typedef struct packed {
    logic  valid;
    addr_t tag;
    addr_t target;
    ctr_t  ctr;
  } btb_entry_t;

  localparam ctr_t CTR_WEAK_TAKEN = 2'b10;
  localparam ctr_t CTR_MAX        = 2'b11;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) begin
      return (c == CTR_MAX) ? c : c + 2'd1;
    end
    return (c == '0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/pc_gen_btb_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational lookup port sees the pre-update contents; updates land on the clock edge.
module pc_gen_btb_btb
  import pc_gen_btb_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned INST_BYTES  = 4,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned OFF   = $clog2(INST_BYTES);
  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned SHIFT = OFF + IDX;

  typedef logic [IDX-1:0] idx_t;

  btb_entry_t mem [BTB_ENTRIES];

  idx_t       lk_idx;
  idx_t       up_idx;
  addr_t      lk_tag;
  addr_t      up_tag;
  btb_entry_t lk_e;
  btb_entry_t up_e;
  btb_entry_t up_new;
  logic       up_hit;
  logic       up_we;

  assign lk_idx = lookup_pc[SHIFT-1:OFF];
  assign up_idx = upd_pc[SHIFT-1:OFF];
  assign lk_tag = addr_t'(lookup_pc) >> SHIFT;
  assign up_tag = addr_t'(upd_pc) >> SHIFT;

  always_comb begin
    lk_e          = mem[lk_idx];
    lookup_taken  = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.ctr[1];
    lookup_target = XLEN'(lk_e.target);
  end

  // A miss that resolved not-taken leaves the resident entry alone.
  always_comb begin
    up_e   = mem[up_idx];
    up_hit = up_e.valid && (up_e.tag == up_tag);
    up_new = up_e;
    up_we  = 1'b0;
    if (upd_valid) begin
      if (up_hit) begin
        up_we      = 1'b1;
        up_new.ctr = ctr_next(up_e.ctr, upd_taken);
        if (upd_taken) begin
          up_new.target = addr_t'(upd_target);
        end
      end else if (upd_taken) begin
        up_we         = 1'b1;
        up_new.valid  = 1'b1;
        up_new.tag    = up_tag;
        up_new.target = addr_t'(upd_target);
        up_new.ctr    = CTR_WEAK_TAKEN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (up_we) begin
      mem[up_idx] <= up_new;
    end
  end

endmodule

// File: rtl/pc_gen_btb.sv
// Registered fetch PC generator: valid/ready handshake, trap/redirect priority mux,
// and optional BTB-driven next-PC prediction.
module pc_gen_btb
  import pc_gen_btb_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int unsigned INST_BYTES  = 4,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter bit          BTB_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_4_o,
  output logic            pc_valid_o,
  input  logic            pc_ready_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_pc_i,
  output logic            flush_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] btb_target;
  logic            btb_taken;
  logic            valid_q;
  logic            flush_q;
  logic            fire;

  assign pc_o          = pc_q;
  assign pc_4_o        = pc_q + XLEN'(INST_BYTES);
  assign pc_valid_o    = valid_q;
  assign flush_o       = flush_q;
  assign fire          = valid_q & pc_ready_i;
  assign pred_taken_o  = btb_taken;
  assign pred_target_o = btb_taken ? btb_target : '0;

  generate
    if (BTB_EN) begin : g_btb
      pc_gen_btb_btb #(
        .XLEN       (XLEN),
        .INST_BYTES (INST_BYTES),
        .BTB_ENTRIES(BTB_ENTRIES)
      ) u_btb (
        .clk          (clk),
        .reset        (reset),
        .lookup_pc    (pc_q),
        .lookup_taken (btb_taken),
        .lookup_target(btb_target),
        .upd_valid    (upd_valid_i),
        .upd_pc       (upd_pc_i),
        .upd_taken    (upd_taken_i),
        .upd_target   (upd_target_i)
      );
    end else begin : g_no_btb
      logic unused_upd;
      assign unused_upd = ^{upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i};
      assign btb_taken  = 1'b0;
      assign btb_target = '0;
    end
  endgenerate

  always_comb begin
    pc_next = pc_q;
    if (trap_valid_i) begin
      pc_next = trap_pc_i;
    end else if (redirect_valid_i) begin
      pc_next = redirect_pc_i;
    end else if (fire && btb_taken) begin
      pc_next = btb_target;
    end else if (fire) begin
      pc_next = pc_4_o;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= XLEN'(RESET_PC);
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_next;
      valid_q <= 1'b1;
      flush_q <= trap_valid_i | redirect_valid_i;
    end
  end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Bench for pc_gen_btb: vector table through a scoreboard queue, plus hand-written
// sequences for reset, same-cycle BTB update, and a 32-bit prediction-disabled instance.
module tb_pc_gen_btb;

  localparam logic [63:0] B = 64'h8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic        flush;
    logic        pred;
    logic [63:0] tgt;
  } exp_t;

  typedef struct {
    logic        ready;
    logic        trap_v;
    logic [63:0] trap_pc;
    logic        redir_v;
    logic [63:0] redir_pc;
    logic        upd_v;
    logic [63:0] upd_pc;
    logic        upd_tk;
    logic [63:0] upd_tgt;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready, trap_v, redir_v, upd_v, upd_tk;
  logic [63:0] trap_pc, redir_pc, upd_pc, upd_tgt;
  logic [63:0] pc, pc4, ptgt;
  logic        pvalid, flush, ptaken;
  logic [31:0] pc32, pc4_32, ptgt32;
  logic        pvalid32, flush32, ptaken32;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pc_gen_btb #(
    .XLEN(64), .RESET_PC(64'h8000_0000), .INST_BYTES(4), .BTB_ENTRIES(16), .BTB_EN(1'b1)
  ) dut (
    .clk(clk), .reset(rst), .pc_o(pc), .pc_4_o(pc4), .pc_valid_o(pvalid), .pc_ready_i(ready),
    .pred_taken_o(ptaken), .pred_target_o(ptgt), .redirect_valid_i(redir_v),
    .redirect_pc_i(redir_pc), .trap_valid_i(trap_v), .trap_pc_i(trap_pc), .flush_o(flush),
    .upd_valid_i(upd_v), .upd_pc_i(upd_pc), .upd_taken_i(upd_tk), .upd_target_i(upd_tgt)
  );

  pc_gen_btb #(
    .XLEN(32), .RESET_PC(64'hFFFF_FFF8), .INST_BYTES(4), .BTB_ENTRIES(16), .BTB_EN(1'b0)
  ) dut32 (
    .clk(clk), .reset(rst), .pc_o(pc32), .pc_4_o(pc4_32), .pc_valid_o(pvalid32),
    .pc_ready_i(1'b1), .pred_taken_o(ptaken32), .pred_target_o(ptgt32),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0), .trap_valid_i(1'b0), .trap_pc_i(32'h0),
    .flush_o(flush32), .upd_valid_i(1'b1), .upd_pc_i(32'hFFFF_FFF8), .upd_taken_i(1'b1),
    .upd_target_i(32'h0000_0010)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic tv, input logic [63:0] tpc,
                     input logic rv, input logic [63:0] rpc,
                     input logic uv, input logic [63:0] upc, input logic utk,
                     input logic [63:0] utgt,
                     input logic [63:0] epc, input logic efl, input logic epr,
                     input logic [63:0] etg);
    vec_t v;
    v.ready = rdy;  v.trap_v = tv;  v.trap_pc = tpc;  v.redir_v = rv;  v.redir_pc = rpc;
    v.upd_v = uv;   v.upd_pc = upc; v.upd_tk = utk;   v.upd_tgt = utgt;
    v.exp.pc = epc; v.exp.flush = efl; v.exp.pred = epr; v.exp.tgt = etg;
    vecs.push_back(v);
  endtask

  task automatic idle();
    ready = 1'b0; trap_v = 1'b0; trap_pc = '0; redir_v = 1'b0; redir_pc = '0;
    upd_v = 1'b0; upd_pc = '0; upd_tk = 1'b0; upd_tgt = '0;
  endtask

  initial begin
    exp_t e;
    idle();
    rst = 1'b0;
    #1 rst = 1'b1;

    // rdy trap tpc rdir rpc upd upc tk utgt | pc flush pred tgt
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,  B,        0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,  B+4,      0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,  B+8,      0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,  B+'hC,    0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,  B+'h10,   0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0,  B+'h10, 0, 0, 0);
    add(0, 1, B+'h100, 1, B+'h200, 0, 0, 0, 0,  B+'h100, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                B+'h100, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 1, B+'h80,      B+'h100, 0, 0, 0);
    add(0, 0, 0, 1, B+'h40, 0, 0, 0, 0,           B+'h40,  1, 1, B+'h80);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                B+'h80,  0, 0, 0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 0, 0,           B+'h80,  0, 0, 0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 0, 0,           B+'h80,  0, 0, 0);
    add(0, 0, 0, 1, B+'h40, 0, 0, 0, 0,           B+'h40,  1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                B+'h44,  0, 0, 0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 0, 0,           B+'h44,  0, 0, 0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 1, B+'h90,      B+'h44,  0, 0, 0);
    add(0, 0, 0, 1, B+'h40, 0, 0, 0, 0,           B+'h40,  1, 0, 0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 1, B+'hA0,      B+'h40,  0, 1, B+'hA0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 1, B+'hA0,      B+'h40,  0, 1, B+'hA0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 1, B+'hA0,      B+'h40,  0, 1, B+'hA0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 0, 0,           B+'h40,  0, 1, B+'hA0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 0, 0,           B+'h40,  0, 0, 0);
    add(0, 0, 0, 0, 0, 1, B+'h40, 1, B+'hA0,      B+'h40,  0, 1, B+'hA0);
    add(0, 0, 0, 0, 0, 1, B+'h440, 1, B+'h500,    B+'h40,  0, 0, 0);
    add(0, 0, 0, 1, B+'h440, 0, 0, 0, 0,          B+'h440, 1, 1, B+'h500);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                B+'h500, 0, 0, 0);
    add(1, 0, 0, 1, B+'h440, 0, 0, 0, 0,          B+'h440, 1, 1, B+'h500);
    add(1, 1, B+'h600, 0, 0, 1, B+'h604, 1, B+'h700, B+'h600, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                B+'h604, 0, 1, B+'h700);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                B+'h700, 0, 0, 0);
    add(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                64'h0,   0, 0, 0);
    add(0, 0, 0, 1, B+'h440, 0, 0, 0, 0,          B+'h440, 1, 1, B+'h500);

    repeat (2) @(negedge clk);
    chk("reset_pc", pc, B);
    chk("reset_pc4", pc4, B+4);
    chk("reset_valid", {63'b0, pvalid}, 64'h0);
    chk("reset_flush", {63'b0, flush}, 64'h0);
    chk("reset_pred", {63'b0, ptaken}, 64'h0);
    chk("reset_pc32", {32'b0, pc32}, 64'hFFFF_FFF8);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      ready = vecs[i].ready;  trap_v = vecs[i].trap_v;   trap_pc = vecs[i].trap_pc;
      redir_v = vecs[i].redir_v; redir_pc = vecs[i].redir_pc;
      upd_v = vecs[i].upd_v;  upd_pc = vecs[i].upd_pc;   upd_tk = vecs[i].upd_tk;
      upd_tgt = vecs[i].upd_tgt;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", i), pc, e.pc);
      chk($sformatf("v%0d_pc4", i), pc4, e.pc + 64'd4);
      chk($sformatf("v%0d_valid", i), {63'b0, pvalid}, 64'h1);
      chk($sformatf("v%0d_flush", i), {63'b0, flush}, {63'b0, e.flush});
      chk($sformatf("v%0d_pred", i), {63'b0, ptaken}, {63'b0, e.pred});
      chk($sformatf("v%0d_tgt", i), ptgt, e.tgt);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a predicted, flushing cycle.
    @(posedge clk);
    #3;
    rst = 1'b1;
    idle();
    #1;
    chk("mid_reset_pc", pc, B);
    chk("mid_reset_valid", {63'b0, pvalid}, 64'h0);
    chk("mid_reset_flush", {63'b0, flush}, 64'h0);
    chk("mid_reset_pred", {63'b0, ptaken}, 64'h0);
    chk("mid_reset_pc32", {32'b0, pc32}, 64'hFFFF_FFF8);
    @(negedge clk);
    rst = 1'b0;

    @(posedge clk); #1;
    chk("post_pc", pc, B);
    chk("post_valid", {63'b0, pvalid}, 64'h1);
    chk("x32_pc_a", {32'b0, pc32}, 64'hFFFF_FFF8);
    chk("x32_valid", {63'b0, pvalid32}, 64'h1);
    @(negedge clk);
    redir_v = 1'b1; redir_pc = B+'h440;
    @(posedge clk); #1;
    chk("post_redir_pc", pc, B+'h440);
    chk("post_redir_flush", {63'b0, flush}, 64'h1);
    chk("btb_lost_pred", {63'b0, ptaken}, 64'h0);
    chk("x32_pc_b", {32'b0, pc32}, 64'hFFFF_FFFC);
    chk("x32_pc4_wrap", {32'b0, pc4_32}, 64'h0);
    @(negedge clk);
    redir_v = 1'b0; upd_v = 1'b1; upd_pc = B+'h440; upd_tk = 1'b1; upd_tgt = B+'h800;
    #1;
    chk("same_cycle_old_pred", {63'b0, ptaken}, 64'h0);
    @(posedge clk); #1;
    chk("after_upd_pred", {63'b0, ptaken}, 64'h1);
    chk("after_upd_tgt", ptgt, B+'h800);
    chk("after_upd_flush", {63'b0, flush}, 64'h0);
    chk("after_upd_pc", pc, B+'h440);
    chk("x32_pc_wrap", {32'b0, pc32}, 64'h0);
    chk("x32_pred_off", {63'b0, ptaken32}, 64'h0);
    chk("x32_tgt_off", {32'b0, ptgt32}, 64'h0);
    chk("x32_flush", {63'b0, flush32}, 64'h0);
    @(negedge clk);
    upd_v = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_gen_btb.md
Name: pc_gen_btb

Overview:
- Next-generation fetch PC unit: replaces the combinational next-PC mux with a registered PC.
- Adds a valid/ready fetch handshake, prioritised trap and branch redirects, and a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Sits between the execute/commit redirect sources and the instruction-fetch stage. Drives the fetch address and its sequential successor each cycle.

Parameters:
- XLEN, 64, address width in bits.
- RESET_PC, 64'h8000_0000, PC loaded on reset (truncated to XLEN).
- INST_BYTES, 4, sequential increment; power of two.
- BTB_ENTRIES, 16, BTB depth; power of two, >=2.
- BTB_EN, 1, 0 = prediction disabled (pred_taken_o tied 0, update ignored).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- pc_o  out  XLEN  current fetch PC.
- pc_4_o  out  XLEN  pc_o + INST_BYTES, modulo 2^XLEN.
- pc_valid_o  out  1  fetch request valid.
- pc_ready_i  in  1  fetch accepts pc_o this cycle.
- pred_taken_o  out  1  BTB predicts taken for pc_o.
- pred_target_o  out  XLEN  predicted target; 0 when pred_taken_o=0.
- redirect_valid_i  in  1  execute-stage redirect (mispredict/jump).
- redirect_pc_i  in  XLEN  redirect target.
- trap_valid_i  in  1  trap/return redirect; highest priority.
- trap_pc_i  in  XLEN  trap target.
- flush_o  out  1  one-cycle pulse after any redirect is applied.
- upd_valid_i  in  1  resolved branch update.
- upd_pc_i  in  XLEN  PC of resolved branch.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  XLEN  actual target.

Behaviour:
- Reset (async assert) values:
  - pc register = RESET_PC.
  - pc_valid_o = 0.
  - flush_o = 0.
  - All BTB valid bits = 0; counters and targets don't-care.
- pc_valid_o rises at the first clock edge after reset deasserts and stays 1 thereafter.
- Handshake: a fire occurs when pc_valid_o & pc_ready_i. Without a fire and without a redirect, pc_o holds.
- Next-PC priority at each edge:
  1. trap_valid_i -> trap_pc_i
  2. redirect_valid_i -> redirect_pc_i
  3. fire & pred_taken_o -> pred_target_o
  4. fire -> pc_4_o
  5. hold
- Redirects apply regardless of pc_ready_i or pc_valid_o. The in-flight request is abandoned; fetch honours flush_o.
- flush_o = registered (trap_valid_i | redirect_valid_i). High exactly in the cycle pc_o first shows the redirect target.
- Redirect targets are used verbatim. No alignment check; misalignment is detected elsewhere.
- All additions wrap modulo 2^XLEN. For example, pc_o = all-ones minus 3 gives pc_4_o = 0.
- BTB indexing and tag:
  - OFF = log2(INST_BYTES), IDX = log2(BTB_ENTRIES).
  - index = pc[OFF+IDX-1:OFF]; tag = pc[XLEN-1:OFF+IDX].
  - Entry fields: valid, tag, target, ctr[1:0].
- Lookup is combinational on pc_o. pred_taken_o = BTB_EN & valid & tag match & ctr[1].
- Update on upd_valid_i, for the entry selected by upd_pc_i:
  - Hit, taken: ctr saturating +1 (max 3); target <= upd_target_i.
  - Hit, not taken: ctr saturating -1 (min 0); target kept.
  - Miss, taken: allocate; overwrite valid=1, new tag, target, ctr=2'b10.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: the lookup sees old contents. The update is visible from the next cycle.
- Updates proceed during redirects and stalls.
- Reset asserted mid-operation forces all reset values immediately. BTB contents are lost.

Decomposition:
- Shared common package holds:
  - typedef addr_t (logic [XLEN-1:0]).
  - typedef btb_entry_t (valid, tag, target, ctr).
  - Constants CTR_WEAK_TAKEN = 2'b10 and CTR_MAX = 2'b11.
- One sub-module, btb: storage array, combinational lookup port, and update port with counter logic.
- pc_gen_btb keeps the PC register, valid/flush registers and the priority mux.

Test Plan:
- Reset release with pc_ready_i=1 constantly -> pc_o = 8000_0000 for 2 cycles (valid low, then first fire), then 8000_0004, 8000_0008, with pc_valid_o=1.
- pc_ready_i=0 for 3 cycles at pc_o=8000_0010 -> pc_o holds 8000_0010; pc_4_o = 8000_0014 throughout.
- trap_valid_i=1 (trap_pc_i=8000_0100) and redirect_valid_i=1 (redirect_pc_i=8000_0200) in the same cycle, pc_ready_i=0 -> next pc_o = 8000_0100, flush_o=1 for exactly 1 cycle.
- Update at upd_pc_i=8000_0040, taken, target 8000_0080 -> ctr=2. Later, when pc_o=8000_0040 fires, pred_taken_o=1 and next pc_o = 8000_0080. After two not-taken updates, ctr=0, pred_taken_o=0 and the next pc_o = 8000_0044.
- Aliasing with BTB_ENTRIES=16: allocate 8000_0040, then a taken update for 8000_0440 (same index) -> pc_o=8000_0040 no longer predicts; pc_o=8000_0440 predicts.
- XLEN=32, pc_o=FFFF_FFFC, fire -> pc_o = 0000_0000. Reset asserted mid-stream -> pc_o = RESET_PC and pred_taken_o = 0 immediately.
